sdf_frame_arbiter: RTL and testbench

//  Shares one streaming radix-2 SDF FFT pipeline between two frame sources.

---
 rtl/sdf_frame_arbiter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sdf_frame_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_frame_arbiter.sv
// -----------------------------------------------------------------------------
// sdf_frame_arbiter
//
// Shares one streaming radix-2 SDF FFT pipeline between two frame sources.
// Whole N-point frames (N = 2**LOG_N) are granted round-robin and streamed
// contiguously into the pipeline. Each grant pushes the source ID into a small
// tag FIFO. The pipeline's in-order, N-length output bursts are then re-labelled
// with the ID at the head of that FIFO.
//
// Ports
//   clock, reset              master clock; synchronous active-high reset
//   s0_frame_rdy / s1_*       source K holds at least one complete frame
//   s0_rd / s1_rd             read strobe to source K (FWFT: data valid same cycle)
//   s0_re/s0_im, s1_re/s1_im  source samples
//   fft_di_en/re/im           pipeline input (registered, 1 cycle after sK_rd)
//   fft_do_en/re/im           pipeline output
//   m_en/re/im                result sample (registered, 1 cycle after fft_do_*)
//   m_src                     source ID of the current result frame
//   m_first / m_last          first / last sample of the result frame
//   err_orphan                sticky: output sample arrived with no tag queued
// -----------------------------------------------------------------------------
module sdf_frame_arbiter #(
    parameter int WIDTH     = 16,
    parameter int LOG_N     = 6,
    parameter int GAP       = 1,
    parameter int TAG_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             s0_frame_rdy,
    output logic             s0_rd,
    input  logic [WIDTH-1:0] s0_re,
    input  logic [WIDTH-1:0] s0_im,

    input  logic             s1_frame_rdy,
    output logic             s1_rd,
    input  logic [WIDTH-1:0] s1_re,
    input  logic [WIDTH-1:0] s1_im,

    output logic             fft_di_en,
    output logic [WIDTH-1:0] fft_di_re,
    output logic [WIDTH-1:0] fft_di_im,

    input  logic             fft_do_en,
    input  logic [WIDTH-1:0] fft_do_re,
    input  logic [WIDTH-1:0] fft_do_im,

    output logic             m_en,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic             m_src,
    output logic             m_first,
    output logic             m_last,
    output logic             err_orphan
);

    localparam logic [LOG_N-1:0] CNT_LAST = '1;
    localparam int               PW       = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int               CW       = $clog2(TAG_DEPTH + 1);
    localparam int               GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);
    localparam logic [CW-1:0]    TAG_FULL = CW'(TAG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP
    } state_t;

    // FSM and input-side registers
    state_t              state_q,   state_d;
    logic                src_q,     src_d;
    logic                rr_q,      rr_d;
    logic [LOG_N-1:0]    in_cnt_q,  in_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;

    // Tag FIFO
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PW-1:0]        wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]        tag_cnt_q, tag_cnt_d;

    // Output-side registers
    logic [LOG_N-1:0]    out_cnt_q,    out_cnt_d;
    logic                err_orphan_q, err_orphan_d;

    logic                fft_di_en_q, fft_di_en_d;
    logic [WIDTH-1:0]    fft_di_re_q, fft_di_re_d;
    logic [WIDTH-1:0]    fft_di_im_q, fft_di_im_d;

    logic                m_en_q,    m_en_d;
    logic [WIDTH-1:0]    m_re_q,    m_re_d;
    logic [WIDTH-1:0]    m_im_q,    m_im_d;
    logic                m_src_q,   m_src_d;
    logic                m_first_q, m_first_d;
    logic                m_last_q,  m_last_d;

    // Arbitration
    logic grant;
    logic grant_src;
    logic tag_full;
    logic tag_empty;
    logic frame_end;
    logic push;
    logic pop;

    assign tag_full  = (tag_cnt_q == TAG_FULL);
    assign tag_empty = (tag_cnt_q == '0);

    always_comb begin
        // On a tie the source that was not granted last wins.
        grant_src = '0;
        if (s0_frame_rdy && s1_frame_rdy) begin
            grant_src = ~rr_q;
        end else begin
            grant_src = s1_frame_rdy;
        end
        grant = (state_q == ST_IDLE) && (s0_frame_rdy || s1_frame_rdy) && !tag_full;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= 1'b0;
            rr_q      <= 1'b1;
            in_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            rr_q      <= rr_d;
            in_cnt_q  <= in_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        rr_d      = rr_q;
        in_cnt_d  = in_cnt_q;
        gap_cnt_d = gap_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    src_d    = grant_src;
                    rr_d     = grant_src;
                    in_cnt_d = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_cnt_d = in_cnt_q + LOG_N'(1);
                if (in_cnt_q == CNT_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (read strobes decoded from state and granted source)
    // -------------------------------------------------------------------------
    always_comb begin
        s0_rd = (state_q == ST_STREAM) && !src_q;
        s1_rd = (state_q == ST_STREAM) &&  src_q;
    end

    // -------------------------------------------------------------------------
    // Datapath and tag FIFO
    // -------------------------------------------------------------------------
    always_comb begin
        // Input side: one register stage between the source FIFO and the pipeline.
        fft_di_en_d = s0_rd | s1_rd;
        fft_di_re_d = '0;
        fft_di_im_d = '0;
        if (s1_rd) begin
            fft_di_re_d = s1_re;
            fft_di_im_d = s1_im;
        end else if (s0_rd) begin
            fft_di_re_d = s0_re;
            fft_di_im_d = s0_im;
        end

        // The pop is taken on the cycle that produces m_last, so the head
        // seen by the following sample (possibly a back-to-back frame) is
        // already the next tag.
        frame_end = fft_do_en && (out_cnt_q == CNT_LAST);
        push      = grant;
        pop       = frame_end && !tag_empty;

        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_cnt_d = tag_cnt_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = grant_src;
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            tag_cnt_d = tag_cnt_q + CW'(1);
        end else if (pop && !push) begin
            tag_cnt_d = tag_cnt_q - CW'(1);
        end

        // out_cnt is LOG_N bits wide, so N-1 -> 0 is the natural wrap.
        out_cnt_d = out_cnt_q;
        if (fft_do_en) begin
            out_cnt_d = out_cnt_q + LOG_N'(1);
        end

        m_en_d    = fft_do_en;
        m_re_d    = fft_do_en ? fft_do_re : '0;
        m_im_d    = fft_do_en ? fft_do_im : '0;
        m_src_d   = fft_do_en && !tag_empty && tag_mem_q[rd_ptr_q];
        m_first_d = fft_do_en && (out_cnt_q == '0);
        m_last_d  = frame_end;

        err_orphan_d = err_orphan_q || (fft_do_en && tag_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_mem_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_cnt_q    <= '0;
            out_cnt_q    <= '0;
            err_orphan_q <= 1'b0;
            fft_di_en_q  <= 1'b0;
            fft_di_re_q  <= '0;
            fft_di_im_q  <= '0;
            m_en_q       <= 1'b0;
            m_re_q       <= '0;
            m_im_q       <= '0;
            m_src_q      <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            tag_mem_q    <= tag_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            out_cnt_q    <= out_cnt_d;
            err_orphan_q <= err_orphan_d;
            fft_di_en_q  <= fft_di_en_d;
            fft_di_re_q  <= fft_di_re_d;
            fft_di_im_q  <= fft_di_im_d;
            m_en_q       <= m_en_d;
            m_re_q       <= m_re_d;
            m_im_q       <= m_im_d;
            m_src_q      <= m_src_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
        end
    end

    assign fft_di_en  = fft_di_en_q;
    assign fft_di_re  = fft_di_re_q;
    assign fft_di_im  = fft_di_im_q;
    assign m_en       = m_en_q;
    assign m_re       = m_re_q;
    assign m_im       = m_im_q;
    assign m_src      = m_src_q;
    assign m_first    = m_first_q;
    assign m_last     = m_last_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdf_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdf_frame_arbiter
//
// Directed bench for sdf_frame_arbiter with default parameters (N = 64,
// GAP = 1, TAG_DEPTH = 4). The bench plays both the frame sources and the
// pipeline output; expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_sdf_frame_arbiter;

    localparam int WIDTH = 16;
    localparam int N     = 64;
    localparam int GAP_C = 1;

    logic             clock;
    logic             reset;
    logic             s0_frame_rdy;
    logic             s0_rd;
    logic [WIDTH-1:0] s0_re;
    logic [WIDTH-1:0] s0_im;
    logic             s1_frame_rdy;
    logic             s1_rd;
    logic [WIDTH-1:0] s1_re;
    logic [WIDTH-1:0] s1_im;
    logic             fft_di_en;
    logic [WIDTH-1:0] fft_di_re;
    logic [WIDTH-1:0] fft_di_im;
    logic             fft_do_en;
    logic [WIDTH-1:0] fft_do_re;
    logic [WIDTH-1:0] fft_do_im;
    logic             m_en;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;
    logic             m_src;
    logic             m_first;
    logic             m_last;
    logic             err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    sdf_frame_arbiter #(
        .WIDTH    (WIDTH),
        .LOG_N    (6),
        .GAP      (GAP_C),
        .TAG_DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .s0_frame_rdy(s0_frame_rdy),
        .s0_rd       (s0_rd),
        .s0_re       (s0_re),
        .s0_im       (s0_im),
        .s1_frame_rdy(s1_frame_rdy),
        .s1_rd       (s1_rd),
        .s1_re       (s1_re),
        .s1_im       (s1_im),
        .fft_di_en   (fft_di_en),
        .fft_di_re   (fft_di_re),
        .fft_di_im   (fft_di_im),
        .fft_do_en   (fft_do_en),
        .fft_do_re   (fft_do_re),
        .fft_do_im   (fft_do_im),
        .m_en        (m_en),
        .m_re        (m_re),
        .m_im        (m_im),
        .m_src       (m_src),
        .m_first     (m_first),
        .m_last      (m_last),
        .err_orphan  (err_orphan)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Plays one N-sample pipeline output burst and checks the labelled result.
    task automatic drive_frame(input logic exp_src, input int base);
        for (int i = 0; i < N; i++) begin
            fft_do_en = 1'b1;
            fft_do_re = 16'(base + i);
            fft_do_im = 16'(base + 16'h0800 + i);
            tick();
            check("m_en",    32'(m_en),    1);
            check("m_src",   32'(m_src),   32'(exp_src));
            check("m_first", 32'(m_first), (i == 0)     ? 1 : 0);
            check("m_last",  32'(m_last),  (i == N - 1) ? 1 : 0);
            check("m_re",    32'(m_re),    32'(16'(base + i)));
            check("m_im",    32'(m_im),    32'(16'(base + 16'h0800 + i)));
        end
    endtask

    initial begin
        int n_grants;
        int gsrc [4];
        int burst_len;
        int low_run;
        int min_low;
        int rd_cnt;
        logic prev_any;
        logic seen;

        reset        = 1'b0;
        s0_frame_rdy = 1'b0;
        s1_frame_rdy = 1'b0;
        s0_re        = '0;
        s0_im        = '0;
        s1_re        = '0;
        s1_im        = '0;
        fft_do_en    = 1'b0;
        fft_do_re    = '0;
        fft_do_im    = '0;

        // Reset state
        do_reset();
        check("rst_s0_rd",      32'(s0_rd),      0);
        check("rst_s1_rd",      32'(s1_rd),      0);
        check("rst_di_en",      32'(fft_di_en),  0);
        check("rst_m_en",       32'(m_en),       0);
        check("rst_m_src",      32'(m_src),      0);
        check("rst_m_first",    32'(m_first),    0);
        check("rst_m_last",     32'(m_last),     0);
        check("rst_err_orphan", 32'(err_orphan), 0);

        // Single request from source 0: 64 read cycles, input burst one cycle later.
        s0_frame_rdy = 1'b1;
        tick();
        s0_frame_rdy = 1'b0;
        for (int i = 0; i < 70; i++) begin
            check("t1_s0_rd", 32'(s0_rd),     (i < N) ? 1 : 0);
            check("t1_s1_rd", 32'(s1_rd),     0);
            check("t1_di_en", 32'(fft_di_en), (i >= 1 && i <= N) ? 1 : 0);
            if (i >= 1 && i <= N) begin
                check("t1_di_re", 32'(fft_di_re), 32'(16'(16'h1000 + i - 1)));
                check("t1_di_im", 32'(fft_di_im), 32'(16'(16'h2000 + i - 1)));
            end
            s0_re = 16'(16'h1000 + i);
            s0_im = 16'(16'h2000 + i);
            tick();
        end
        drive_frame(1'b0, 16'h3000);
        fft_do_en = 1'b0;
        tick();
        check("t1_m_en_off",  32'(m_en),       0);
        check("t1_no_orphan", 32'(err_orphan), 0);

        // Both sources always ready, pipeline stalled: four alternating grants,
        // then the full tag FIFO blocks any further grant.
        s0_frame_rdy = 1'b1;
        s1_frame_rdy = 1'b1;
        do_reset();
        n_grants  = 0;
        burst_len = 0;
        low_run   = 0;
        min_low   = 1000;
        prev_any  = 1'b0;
        seen      = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if ((s0_rd || s1_rd) && !prev_any) begin
                if (n_grants < 4) gsrc[n_grants] = s1_rd ? 1 : 0;
                n_grants++;
            end
            prev_any = s0_rd || s1_rd;
            if (fft_di_en) begin
                if (burst_len == 0 && seen && low_run < min_low) min_low = low_run;
                burst_len++;
            end else begin
                if (burst_len > 0) begin
                    check("t2_burst_len", 32'(burst_len), N);
                    seen      = 1'b1;
                    burst_len = 0;
                    low_run   = 0;
                end
                low_run++;
            end
        end
        check("t3_grant_count", 32'(n_grants), 4);
        check("t2_grant0_src",  32'(gsrc[0]),  0);
        check("t2_grant1_src",  32'(gsrc[1]),  1);
        check("t2_grant2_src",  32'(gsrc[2]),  0);
        check("t2_grant3_src",  32'(gsrc[3]),  1);
        check("t2_min_gap_ok",  (min_low >= GAP_C + 1) ? 1 : 0, 1);

        // Retiring one frame frees a tag slot; source 0 wins the following tie.
        drive_frame(1'b0, 16'h4000);
        fft_do_en = 1'b0;
        check("t3_idle_at_pop", 32'(s0_rd | s1_rd), 0);
        tick();
        check("t3_regrant_s0", 32'(s0_rd), 1);
        check("t3_regrant_s1", 32'(s1_rd), 0);

        // Two back-to-back result frames: source 1 then source 0.
        drive_frame(1'b1, 16'h5000);
        drive_frame(1'b0, 16'h6000);
        fft_do_en    = 1'b0;
        s0_frame_rdy = 1'b0;
        s1_frame_rdy = 1'b0;
        tick();
        check("t4_m_en_off", 32'(m_en), 0);

        // Reset in the middle of a frame.
        do_reset();
        s0_frame_rdy = 1'b1;
        tick();
        s0_frame_rdy = 1'b0;
        repeat (10) tick();
        check("t5_rd_before", 32'(s0_rd), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rd_after",    32'(s0_rd),     0);
        check("t5_di_en_after", 32'(fft_di_en), 0);

        // Output with no frame queued: the abandoned tag must be gone.
        fft_do_en = 1'b1;
        fft_do_re = 16'h0777;
        fft_do_im = 16'h0888;
        tick();
        fft_do_en = 1'b0;
        check("t6_m_en",      32'(m_en),       1);
        check("t6_m_src",     32'(m_src),      0);
        check("t6_m_first",   32'(m_first),    1);
        check("t6_m_re",      32'(m_re),       32'h0777);
        check("t6_err_set",   32'(err_orphan), 1);
        repeat (5) tick();
        check("t6_m_en_off",  32'(m_en),       0);
        check("t6_err_stick", 32'(err_orphan), 1);

        // A fresh grant after the aborted frame streams a full frame.
        s0_frame_rdy = 1'b1;
        tick();
        s0_frame_rdy = 1'b0;
        rd_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (s0_rd) rd_cnt++;
            tick();
        end
        check("t5_fresh_rd_len", 32'(rd_cnt),     N);
        check("t6_err_still",    32'(err_orphan), 1);

        do_reset();
        check("t6_err_cleared", 32'(err_orphan), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
